// File: rtl/relu_arbiter.sv
// relu_arbiter: round-robin front end that shares one ReLU unit among NUM_REQ
// channels, tracks the producing channel through the ReLU pipeline, and
// buffers activated words in a first-word-fall-through FIFO. Grants are
// issued only while a free credit guarantees a FIFO slot for the result.
module relu_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 20,
  parameter int RELU_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         relu_in,
  input  logic [DATA_WIDTH-1:0]         relu_out,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_WIDTH-1:0]           out_id,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [RELU_LATENCY-1:0] tagValid_q;
  logic [ID_WIDTH-1:0]   tagId_q [RELU_LATENCY];

  logic [DATA_WIDTH-1:0] memData_q [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]   memId_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [CNT_W-1:0]      inflight;
  logic [CNT_W:0]        occupancy;
  logic                  haveCredit;
  logic                  grantAny;
  logic [ID_WIDTH-1:0]   grantIdx;
  logic [ID_WIDTH-1:0]   scanId;
  int                    scanIdx;
  logic                  push;
  logic                  pop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Credit accounting: every valid tag stage and every buffered entry owns a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int s = 0; s < RELU_LATENCY; s++) begin
      inflight = inflight + CNT_W'(tagValid_q[s]);
    end
    occupancy  = {1'b0, count_q} + {1'b0, inflight};
    haveCredit = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
  end

  // Round-robin scan from ptr; drives the one-hot grant, the ReLU input and the next pointer.
  always_comb begin
    grantAny  = 1'b0;
    grantIdx  = '0;
    scanIdx   = 0;
    scanId    = '0;
    req_ready = '0;
    relu_in   = '0;
    ptr_d     = ptr_q;
    if (!rst && haveCredit) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        scanIdx = int'(ptr_q) + i;
        if (scanIdx >= NUM_REQ) begin
          scanIdx = scanIdx - NUM_REQ;
        end
        scanId = ID_WIDTH'(scanIdx);
        if (!grantAny && req_valid[scanId]) begin
          grantAny = 1'b1;
          grantIdx = scanId;
        end
      end
    end
    if (grantAny) begin
      req_ready[grantIdx] = 1'b1;
      relu_in = req_data[grantIdx*DATA_WIDTH +: DATA_WIDTH];
      if (grantIdx == ID_WIDTH'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grantIdx + ID_WIDTH'(1);
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Tag pipeline shadowing the ReLU stages; never stalls because credits reserve the FIFO slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tagValid_q <= '0;
      for (int s = 0; s < RELU_LATENCY; s++) begin
        tagId_q[s] <= '0;
      end
    end else begin
      tagValid_q[0] <= grantAny;
      tagId_q[0]    <= grantIdx;
      for (int s = 1; s < RELU_LATENCY; s++) begin
        tagValid_q[s] <= tagValid_q[s-1];
        tagId_q[s]    <= tagId_q[s-1];
      end
    end
  end

  // FIFO control: push when the last tag stage is valid, pop on a downstream handshake.
  always_comb begin
    push    = tagValid_q[RELU_LATENCY-1];
    pop     = out_valid && out_ready;
    wrPtr_d = push ? nextPtr(wrPtr_q) : wrPtr_q;
    rdPtr_d = pop ? nextPtr(rdPtr_q) : rdPtr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers; reset discards everything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      memData_q[wrPtr_q] <= relu_out;
      memId_q[wrPtr_q]   <= tagId_q[RELU_LATENCY-1];
    end
  end

  // Head of FIFO is presented directly; outputs read as zero when empty.
  always_comb begin
    out_valid = (count_q != '0);
    out_data  = out_valid ? memData_q[rdPtr_q] : '0;
    out_id    = out_valid ? memId_q[rdPtr_q] : '0;
    busy      = (inflight != '0) || (count_q != '0);
  end

  // A push without a simultaneous pop must always find room.
  assert property (@(posedge clk) disable iff (rst)
    (push && !pop) |-> (count_q < CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_relu_arbiter.sv
// tb_relu_arbiter: directed bench for relu_arbiter with a behavioural
// one-stage ReLU and a queue of expected {id, activated word} entries.
module tb_relu_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 20;
  localparam int LAT     = 1;
  localparam int DEPTH   = 4;
  localparam int IDW     = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NUM_REQ-1:0]    reqValid = '0;
  logic [NUM_REQ*DW-1:0] reqData = '0;
  logic [NUM_REQ-1:0]    reqReady;
  logic [DW-1:0]         reluIn;
  logic [DW-1:0]         reluOut;
  logic                  outValid;
  logic [DW-1:0]         outData;
  logic [IDW-1:0]        outId;
  logic                  outReady = 1'b0;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } exp_t;

  exp_t sbQ[$];

  always #5 clk = ~clk;

  relu_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_WIDTH(DW),
    .RELU_LATENCY(LAT),
    .FIFO_DEPTH(DEPTH),
    .ID_WIDTH(IDW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(reqValid),
    .req_data(reqData),
    .req_ready(reqReady),
    .relu_in(reluIn),
    .relu_out(reluOut),
    .out_valid(outValid),
    .out_data(outData),
    .out_id(outId),
    .out_ready(outReady),
    .busy(busy)
  );

  // Behavioural shared ReLU: one register stage, negatives clamp to zero.
  always_ff @(posedge clk) begin
    reluOut <= reluIn[DW-1] ? '0 : reluIn;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [NUM_REQ*DW-1:0] randWords();
    logic [NUM_REQ*DW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      r[i*DW +: DW] = DW'($urandom);
    end
    return r;
  endfunction

  // One clock cycle: drive inputs, sample at the falling edge, score, then step past the rising edge.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*DW-1:0] d,
                               input logic rdy, output logic [NUM_REQ-1:0] grantSeen,
                               output logic validSeen);
    exp_t          e;
    logic [DW-1:0] w;
    logic [DW-1:0] expRelu;
    reqValid = v;
    reqData  = d;
    outReady = rdy;
    @(negedge clk);
    grantSeen = reqReady;
    validSeen = outValid;
    expRelu   = '0;
    checkOutput("grant_onehot0", 64'($onehot0(reqReady)), 64'd1);
    checkOutput("grant_only_valid", 64'(reqReady & ~v), 64'd0);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reqReady[i]) begin
        w       = d[i*DW +: DW];
        expRelu = w;
        e.id    = IDW'(i);
        e.data  = w[DW-1] ? '0 : w;
        sbQ.push_back(e);
      end
    end
    checkOutput("relu_in", 64'(reluIn), 64'(expRelu));
    if (outValid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_out_valid", 64'(outValid), 64'd0);
      end else begin
        e = sbQ[0];
        checkOutput("out_data", 64'(outData), 64'(e.data));
        checkOutput("out_id", 64'(outId), 64'(e.id));
        if (rdy) begin
          void'(sbQ.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset away from the clock edge, check immediate effects, release synchronously.
  task automatic doReset();
    rst      = 1'b1;
    reqValid = '1;
    reqData  = randWords();
    outReady = 1'b1;
    #1;
    sbQ.delete();
    checkOutput("rst_req_ready", 64'(reqReady), 64'd0);
    checkOutput("rst_relu_in", 64'(reluIn), 64'd0);
    checkOutput("rst_out_valid", 64'(outValid), 64'd0);
    checkOutput("rst_out_data", 64'(outData), 64'd0);
    checkOutput("rst_out_id", 64'(outId), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    reqValid = '0;
  endtask

  initial begin
    logic [NUM_REQ-1:0]    g;
    logic                  vs;
    logic [NUM_REQ*DW-1:0] d;

    doReset();

    // Single requester on channel 2: -5 then 7.
    d = '0;
    d[2*DW +: DW] = -20'sd5;
    applyStimulus(4'b0100, d, 1'b1, g, vs);
    checkOutput("single_grant_a", 64'(g), 64'h4);
    checkOutput("single_valid_a", 64'(vs), 64'd0);
    d[2*DW +: DW] = 20'd7;
    applyStimulus(4'b0100, d, 1'b1, g, vs);
    checkOutput("single_grant_b", 64'(g), 64'h4);
    checkOutput("single_valid_b", 64'(vs), 64'd0);
    applyStimulus(4'b0000, '0, 1'b1, g, vs);
    checkOutput("single_valid_c", 64'(vs), 64'd1);
    applyStimulus(4'b0000, '0, 1'b1, g, vs);
    checkOutput("single_valid_d", 64'(vs), 64'd1);
    applyStimulus(4'b0000, '0, 1'b1, g, vs);
    checkOutput("single_valid_e", 64'(vs), 64'd0);
    checkOutput("single_busy", 64'(busy), 64'd0);
    checkOutput("single_drained", 64'(sbQ.size()), 64'd0);

    // Fairness: all channels requesting continuously.
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus('1, randWords(), 1'b1, g, vs);
      checkOutput("fair_grant", 64'(g), 64'(1) << (k % 4));
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus('0, '0, 1'b1, g, vs);
    end
    checkOutput("fair_drained", 64'(sbQ.size()), 64'd0);
    checkOutput("fair_busy", 64'(busy), 64'd0);

    // Back-pressure, a one-cycle pop coinciding with a push, then recovery.
    for (int k = 0; k < 4; k++) begin
      applyStimulus('1, randWords(), 1'b0, g, vs);
      checkOutput("bp_grant_fill", 64'(g), 64'(1) << k);
    end
    applyStimulus('1, randWords(), 1'b1, g, vs);
    checkOutput("bp_grant_full_pulse", 64'(g), 64'd0);
    applyStimulus('1, randWords(), 1'b0, g, vs);
    checkOutput("bp_grant_after_pulse", 64'(g), 64'h1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus('1, randWords(), 1'b0, g, vs);
      checkOutput("bp_grant_stalled", 64'(g), 64'd0);
    end
    applyStimulus('1, randWords(), 1'b1, g, vs);
    checkOutput("bp_grant_first_pop", 64'(g), 64'd0);
    applyStimulus('1, randWords(), 1'b1, g, vs);
    checkOutput("bp_grant_resume_a", 64'(g), 64'h2);
    applyStimulus('1, randWords(), 1'b1, g, vs);
    checkOutput("bp_grant_resume_b", 64'(g), 64'h4);
    for (int k = 0; k < 6; k++) begin
      applyStimulus('0, '0, 1'b1, g, vs);
    end
    checkOutput("bp_drained", 64'(sbQ.size()), 64'd0);
    checkOutput("bp_busy", 64'(busy), 64'd0);

    // Reset with three buffered words and one in flight.
    for (int k = 0; k < 4; k++) begin
      applyStimulus('1, randWords(), 1'b0, g, vs);
      checkOutput("mid_grant", 64'(g), 64'(1) << ((3 + k) % 4));
    end
    checkOutput("mid_busy_before", 64'(busy), 64'd1);
    checkOutput("mid_valid_before", 64'(outValid), 64'd1);
    doReset();
    applyStimulus('1, randWords(), 1'b1, g, vs);
    checkOutput("mid_grant_restart", 64'(g), 64'h1);
    checkOutput("mid_valid_after", 64'(vs), 64'd0);
    applyStimulus('1, randWords(), 1'b1, g, vs);
    checkOutput("mid_grant_next", 64'(g), 64'h2);
    for (int k = 0; k < 5; k++) begin
      applyStimulus('0, '0, 1'b1, g, vs);
    end
    checkOutput("mid_drained", 64'(sbQ.size()), 64'd0);
    checkOutput("mid_busy_end", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
